// File: rtl/rpn_stack_alu_pkg.sv
// Shared opcode encodings and control types for the RPN stack engine.
package rpn_stack_alu_pkg;

  localparam logic [2:0] OP_PUSH  = 3'd0;
  localparam logic [2:0] OP_POP   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_MUL   = 3'd4;
  localparam logic [2:0] OP_DUP   = 3'd5;
  localparam logic [2:0] OP_SWAP  = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/rpn_seq_mult.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, low WIDTH bits kept.
// The first step is folded into the start edge so that done rises after
// WIDTH-1 further edges and the consumer writes on the WIDTH-th edge.
module rpn_seq_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int unsigned CNTW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNTW-1:0]  cnt;

  // Latch operands with first partial product, then accumulate one bit per edge
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc    <= b[0] ? a : '0;
        mcand  <= a << 1;
        mplier <= b >> 1;
        cnt    <= CNTW'(WIDTH - 1);
        busy   <= (WIDTH > 1);
        done   <= (WIDTH == 1);
      end else if (busy) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CNTW'(1);
        if (cnt == CNTW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign result = acc;

endmodule

// File: rtl/rpn_stack_alu.sv
// RPN operand stack with add/sub/mul/dup/swap, valid/ready op handshake and sticky errors.
module rpn_stack_alu
  import rpn_stack_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [2:0]                 op,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           top,
  output logic [WIDTH-1:0]           second,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       done,
  output logic                       err_ovf,
  output logic                       err_unf
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);

  logic [WIDTH-1:0] stack [DEPTH];
  state_e           state, state_nxt;

  logic [CW-1:0]    count_nxt;
  logic             done_nxt;
  logic             set_ovf, set_unf, clr_err;
  logic             wa_en, wb_en;
  logic [IW-1:0]    wa_idx, wb_idx;
  logic [WIDTH-1:0] wa_dat, wb_dat;

  logic [IW-1:0]    idx_push, idx_top, idx_sec;
  logic             has1, has2;

  logic             mult_start, mult_busy, mult_done;
  logic [WIDTH-1:0] mult_result;

  assign idx_push = IW'(count);
  assign idx_top  = IW'(count - CW'(1));
  assign idx_sec  = IW'(count - CW'(2));
  assign has1     = (count >= CW'(1));
  assign has2     = (count >= CW'(2));

  assign top      = has1 ? stack[idx_top] : '0;
  assign second   = has2 ? stack[idx_sec] : '0;
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign op_ready = (state == S_IDLE) && !mult_busy;

  rpn_seq_mult #(
    .WIDTH(WIDTH)
  ) u_mult (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .start   (mult_start),
    .a       (second),
    .b       (top),
    .busy    (mult_busy),
    .result  (mult_result),
    .done    (mult_done)
  );

  // Decode accepted op into stack writes, count update, error flags and next state
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    done_nxt   = 1'b0;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    clr_err    = 1'b0;
    wa_en      = 1'b0;
    wa_idx     = '0;
    wa_dat     = '0;
    wb_en      = 1'b0;
    wb_idx     = '0;
    wb_dat     = '0;
    mult_start = 1'b0;

    case (state)
      S_IDLE: begin
        if (op_valid && op_ready) begin
          done_nxt = 1'b1;
          case (op)
            OP_PUSH: begin
              if (full) begin
                set_ovf = 1'b1;
              end else begin
                wa_en     = 1'b1;
                wa_idx    = idx_push;
                wa_dat    = data_in;
                count_nxt = count + CW'(1);
              end
            end
            OP_POP: begin
              if (!has1) set_unf = 1'b1;
              else       count_nxt = count - CW'(1);
            end
            OP_ADD, OP_SUB: begin
              if (!has2) begin
                set_unf = 1'b1;
              end else begin
                wa_en     = 1'b1;
                wa_idx    = idx_sec;
                wa_dat    = (op == OP_ADD) ? (second + top) : (second - top);
                count_nxt = count - CW'(1);
              end
            end
            OP_MUL: begin
              if (!has2) begin
                set_unf = 1'b1;
              end else begin
                mult_start = 1'b1;
                done_nxt   = 1'b0;
                state_nxt  = S_MUL;
              end
            end
            OP_DUP: begin
              if (!has1) begin
                set_unf = 1'b1;
              end else if (full) begin
                set_ovf = 1'b1;
              end else begin
                wa_en     = 1'b1;
                wa_idx    = idx_push;
                wa_dat    = top;
                count_nxt = count + CW'(1);
              end
            end
            OP_SWAP: begin
              if (!has2) begin
                set_unf = 1'b1;
              end else begin
                wa_en  = 1'b1;
                wa_idx = idx_top;
                wa_dat = second;
                wb_en  = 1'b1;
                wb_idx = idx_sec;
                wb_dat = top;
              end
            end
            default: begin
              count_nxt = '0;
              clr_err   = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        if (mult_done) begin
          wa_en     = 1'b1;
          wa_idx    = idx_sec;
          wa_dat    = mult_result;
          count_nxt = count - CW'(1);
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, stack array, pointer, done pulse and sticky error registers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      count   <= '0;
      done    <= 1'b0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        stack[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      done  <= done_nxt;
      if (wa_en) stack[wa_idx] <= wa_dat;
      if (wb_en) stack[wb_idx] <= wb_dat;
      err_ovf <= clr_err ? 1'b0 : (err_ovf | set_ovf);
      err_unf <= clr_err ? 1'b0 : (err_unf | set_unf);
    end
  end

endmodule

// File: tb/tb_rpn_stack_alu.sv
// Directed plus randomized bench for rpn_stack_alu against a queue-based stack model.
module tb_rpn_stack_alu;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic         CLOCK_50 = 1'b0;
  logic         reset;
  logic         op_valid;
  logic         op_ready;
  logic [2:0]   op;
  logic [W-1:0] data_in;
  logic [W-1:0] top;
  logic [W-1:0] second;
  logic [2:0]   count;
  logic         empty;
  logic         full;
  logic         done;
  logic         err_ovf;
  logic         err_unf;

  int vectors     = 0;
  int miscompares = 0;

  int model[$];
  bit m_ovf;
  bit m_unf;

  always #5 CLOCK_50 = ~CLOCK_50;

  rpn_stack_alu #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op      (op),
    .data_in (data_in),
    .top     (top),
    .second  (second),
    .count   (count),
    .empty   (empty),
    .full    (full),
    .done    (done),
    .err_ovf (err_ovf),
    .err_unf (err_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare all visible stack outputs against the model
  task automatic chk_state(input string tag);
    int n;
    n = model.size();
    chk({tag, ".count"},  32'(count),   32'(n));
    chk({tag, ".top"},    32'(top),     (n >= 1) ? 32'(model[n-1]) : 32'd0);
    chk({tag, ".second"}, 32'(second),  (n >= 2) ? 32'(model[n-2]) : 32'd0);
    chk({tag, ".empty"},  32'(empty),   32'(n == 0));
    chk({tag, ".full"},   32'(full),    32'(n == int'(D)));
    chk({tag, ".ovf"},    32'(err_ovf), 32'(m_ovf));
    chk({tag, ".unf"},    32'(err_unf), 32'(m_unf));
  endtask

  // Behavioural effect of one op on the model stack
  task automatic model_apply(input logic [2:0] o, input logic [W-1:0] d);
    int n, a, b, r;
    n = model.size();
    case (o)
      3'd0: if (n == int'(D)) m_ovf = 1; else model.push_back(int'(d));
      3'd1: if (n == 0) m_unf = 1; else void'(model.pop_back());
      3'd2, 3'd3, 3'd4: begin
        if (n < 2) m_unf = 1;
        else begin
          a = model[n-2];
          b = model[n-1];
          void'(model.pop_back());
          void'(model.pop_back());
          if (o == 3'd2)      r = (a + b) & 255;
          else if (o == 3'd3) r = (a - b) & 255;
          else                r = (a * b) & 255;
          model.push_back(r);
        end
      end
      3'd5: begin
        if (n == 0) m_unf = 1;
        else if (n == int'(D)) m_ovf = 1;
        else model.push_back(model[n-1]);
      end
      3'd6: begin
        if (n < 2) m_unf = 1;
        else begin
          a = model[n-1];
          model[n-1] = model[n-2];
          model[n-2] = a;
        end
      end
      default: begin
        model.delete();
        m_ovf = 0;
        m_unf = 0;
      end
    endcase
  endtask

  // Issue one op, follow the multiply window when it is accepted, then check
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] d, input bit hold);
    bit mul_busy;
    int pre_n, lo, k;
    pre_n    = model.size();
    mul_busy = (o == 3'd4) && (pre_n >= 2);
    @(negedge CLOCK_50);
    op_valid = 1'b1;
    op       = o;
    data_in  = d;
    @(posedge CLOCK_50);
    #1;
    if (mul_busy && hold) begin
      op      = 3'd0;
      data_in = 8'hEE;
    end else begin
      op_valid = 1'b0;
    end
    if (mul_busy) begin
      chk("mul.ready_drop", 32'(op_ready), 32'd0);
      chk("mul.done_early", 32'(done), 32'd0);
      chk("mul.frozen", 32'(count), 32'(pre_n));
      lo = 1;
      for (k = 0; k < 20; k++) begin
        @(posedge CLOCK_50);
        #1;
        if (op_ready) break;
        lo++;
      end
      op_valid = 1'b0;
      if (k == 20) chk("mul.timeout", 32'd0, 32'd1);
      chk("mul.ready_low_cycles", 32'(lo), 32'(W));
      chk("mul.done", 32'(done), 32'd1);
    end else begin
      chk("op.done", 32'(done), 32'd1);
      chk("op.ready", 32'(op_ready), 32'd1);
    end
    model_apply(o, d);
    chk_state("op");
    @(posedge CLOCK_50);
    #1;
    chk("op.done_pulse_end", 32'(done), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    op_valid = 1'b0;
    op       = 3'd0;
    data_in  = '0;
    m_ovf    = 0;
    m_unf    = 0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk_state("reset");
    chk("reset.ready", 32'(op_ready), 32'd1);
    chk("reset.done", 32'(done), 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b0;

    // Basic ops
    do_op(3'd0, 8'd5, 0);
    do_op(3'd0, 8'd3, 0);
    do_op(3'd3, 8'd0, 0);
    chk("sub.top", 32'(top), 32'd2);
    do_op(3'd0, 8'd7, 0);
    do_op(3'd6, 8'd0, 0);
    chk("swap.top", 32'(top), 32'd2);
    chk("swap.second", 32'(second), 32'd7);
    do_op(3'd7, 8'd0, 0);

    // Wrap-around
    do_op(3'd0, 8'd200, 0);
    do_op(3'd0, 8'd100, 0);
    do_op(3'd2, 8'd0, 0);
    chk("add_wrap.top", 32'(top), 32'd44);
    do_op(3'd0, 8'd1, 0);
    do_op(3'd3, 8'd0, 0);
    chk("sub.top43", 32'(top), 32'd43);
    do_op(3'd0, 8'd0, 0);
    do_op(3'd0, 8'd1, 0);
    do_op(3'd3, 8'd0, 0);
    chk("sub_wrap.top", 32'(top), 32'd255);
    do_op(3'd7, 8'd0, 0);

    // Multiply timing, with a PUSH held on the bus during the busy window
    do_op(3'd0, 8'd12, 0);
    do_op(3'd0, 8'd11, 0);
    do_op(3'd4, 8'd0, 1);
    chk("mul.top132", 32'(top), 32'd132);
    chk("mul.count1", 32'(count), 32'd1);
    do_op(3'd0, 8'd20, 0);
    do_op(3'd4, 8'd0, 0);
    chk("mul.top80", 32'(top), 32'd80);
    do_op(3'd7, 8'd0, 0);

    // Overflow
    for (int i = 1; i <= 4; i++) do_op(3'd0, 8'(i), 0);
    chk("ovf.full", 32'(full), 32'd1);
    do_op(3'd0, 8'd9, 0);
    chk("ovf.flag", 32'(err_ovf), 32'd1);
    chk("ovf.top", 32'(top), 32'd4);
    do_op(3'd5, 8'd0, 0);
    do_op(3'd7, 8'd0, 0);
    chk("clr.empty", 32'(empty), 32'd1);
    chk("clr.ovf", 32'(err_ovf), 32'd0);

    // Underflow
    do_op(3'd1, 8'd0, 0);
    chk("unf.flag", 32'(err_unf), 32'd1);
    do_op(3'd0, 8'd6, 0);
    do_op(3'd2, 8'd0, 0);
    chk("unf.top", 32'(top), 32'd6);
    do_op(3'd4, 8'd0, 0);
    do_op(3'd5, 8'd0, 0);
    do_op(3'd5, 8'd0, 0);
    do_op(3'd7, 8'd0, 0);
    do_op(3'd5, 8'd0, 0);
    chk("dup_empty.ovf", 32'(err_ovf), 32'd0);
    do_op(3'd7, 8'd0, 0);

    // Random ops against the model
    for (int i = 0; i < 300; i++) begin
      do_op(3'($urandom_range(0, 7)), 8'($urandom), bit'($urandom_range(0, 1)));
    end

    // Reset asserted between edges in the middle of a multiply
    do_op(3'd7, 8'd0, 0);
    do_op(3'd0, 8'd3, 0);
    do_op(3'd0, 8'd4, 0);
    @(negedge CLOCK_50);
    op_valid = 1'b1;
    op       = 3'd4;
    @(posedge CLOCK_50);
    #1;
    op_valid = 1'b0;
    chk("rstmul.busy", 32'(op_ready), 32'd0);
    repeat (3) @(posedge CLOCK_50);
    #3;
    reset = 1'b1;
    #1;
    model.delete();
    m_ovf = 0;
    m_unf = 0;
    chk_state("rstmul");
    chk("rstmul.ready", 32'(op_ready), 32'd1);
    chk("rstmul.done", 32'(done), 32'd0);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLOCK_50);
      #1;
      chk("rstmul.no_done", 32'(done), 32'd0);
    end
    chk_state("rstmul.after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
